// File: rtl/mac_result_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_decoder_if
// Brief    : Handshake and data bundle for the MAC result decoder.
// Revision : 1.0
// ============================================================================
interface mac_result_decoder_if #(
    parameter int A_W = 31,
    parameter int M_W = 12,
    parameter int P_W = 46,
    parameter int C_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   a_i;
    logic [P_W-1:0]   prod_i;
    logic [C_W:0]     p_i;
    logic [C_W:0]     q_i;
    logic             out_valid;
    logic             out_ready;
    logic [M_W-1:0]   m_o;
    logic             rem_nz;
    logic [C_W-1:0]   c_o;
    logic [C_W-1:0]   d_o;
    logic             err_div0;
    logic             err_ovf;
    logic             err_parity;

    modport master (
        output in_valid, a_i, prod_i, p_i, q_i, out_ready,
        input  in_ready, out_valid, m_o, rem_nz, c_o, d_o,
               err_div0, err_ovf, err_parity
    );

    modport slave (
        input  in_valid, a_i, prod_i, p_i, q_i, out_ready,
        output in_ready, out_valid, m_o, rem_nz, c_o, d_o,
               err_div0, err_ovf, err_parity
    );
endinterface
`default_nettype wire

// File: rtl/mac_result_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_decoder
// Brief    : Recovers multiplier (serial restoring divide) and sum/diff
//            operands from MAC result buses.
// Revision : 1.0
// ============================================================================
module mac_result_decoder #(
    parameter int A_W = 31,
    parameter int M_W = 12,
    parameter int P_W = 46,
    parameter int C_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mac_result_decoder_if.slave   bus
);
    localparam int         c_HI_W  = P_W - M_W;
    localparam int         c_CNT_W = (M_W > 1) ? $clog2(M_W) : 1;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CHECK = 2'd1;
    localparam logic [1:0] c_DIV   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic [A_W-1:0]     r_a;
    logic [P_W-1:0]     r_prod;
    logic [C_W:0]       r_p;
    logic [C_W:0]       r_q;
    logic [A_W-1:0]     r_rem;
    logic [M_W-1:0]     r_low;
    logic [c_CNT_W-1:0] r_cnt;

    logic [M_W-1:0]     r_m;
    logic               r_rem_nz;
    logic [C_W-1:0]     r_c;
    logic [C_W-1:0]     r_d;
    logic               r_err_div0;
    logic               r_err_ovf;
    logic               r_err_parity;

    logic               w_accept;
    logic [c_HI_W-1:0]  w_hi;
    logic               w_ovf;
    logic [C_W:0]       w_sum;
    logic [C_W:0]       w_diff;
    logic [A_W:0]       w_shift;
    logic [A_W:0]       w_sub;
    logic               w_ge;
    logic [A_W-1:0]     w_rem_next;
    logic [M_W-1:0]     w_quo_next;
    logic               w_unused;

    assign w_accept = bus.in_valid && (r_state == c_IDLE);

    // prod >= (a << M_W) is equivalent to comparing only the bits above M_W.
    assign w_hi   = r_prod[P_W-1:M_W];
    assign w_ovf  = (w_hi >= c_HI_W'(r_a));

    assign w_sum  = r_p + r_q;
    assign w_diff = r_p - r_q;

    // R stays below a, so {R, bit} never exceeds A_W+1 bits.
    assign w_shift    = {r_rem, r_low[M_W-1]};
    assign w_sub      = w_shift - {1'b0, r_a};
    assign w_ge       = (w_shift >= {1'b0, r_a});
    assign w_rem_next = w_ge ? w_sub[A_W-1:0] : w_shift[A_W-1:0];
    // r_low shifts dividend bits out the top and quotient bits in the bottom.
    assign w_quo_next = {r_low[M_W-2:0], w_ge};

    assign w_unused = ^{w_sum[0], w_diff[0], w_sub[A_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.in_valid) w_state_next = c_CHECK;
            c_CHECK: w_state_next = ((r_a == '0) || w_ovf) ? c_DONE : c_DIV;
            c_DIV:   if (r_cnt == '0) w_state_next = c_DONE;
            c_DONE:  if (bus.out_ready) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_prod       <= '0;
            r_p          <= '0;
            r_q          <= '0;
            r_rem        <= '0;
            r_low        <= '0;
            r_cnt        <= '0;
            r_m          <= '0;
            r_rem_nz     <= 1'b0;
            r_c          <= '0;
            r_d          <= '0;
            r_err_div0   <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_parity <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_a          <= bus.a_i;
                        r_prod       <= bus.prod_i;
                        r_p          <= bus.p_i;
                        r_q          <= bus.q_i;
                        r_m          <= '0;
                        r_rem_nz     <= 1'b0;
                        r_c          <= '0;
                        r_d          <= '0;
                        r_err_div0   <= 1'b0;
                        r_err_ovf    <= 1'b0;
                        r_err_parity <= 1'b0;
                    end
                end
                c_CHECK: begin
                    r_c          <= w_sum[C_W:1];
                    r_d          <= w_diff[C_W:1];
                    r_err_parity <= r_p[0] ^ r_q[0];
                    if (r_a == '0) begin
                        r_err_div0 <= 1'b1;
                    end else if (w_ovf) begin
                        r_err_ovf <= 1'b1;
                    end else begin
                        r_rem <= w_hi[A_W-1:0];
                        r_low <= r_prod[M_W-1:0];
                        r_cnt <= c_CNT_W'(M_W - 1);
                    end
                end
                c_DIV: begin
                    r_rem <= w_rem_next;
                    r_low <= w_quo_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_m      <= w_quo_next;
                        r_rem_nz <= (w_rem_next != '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == c_IDLE) && !rst;
    assign bus.out_valid  = (r_state == c_DONE);
    assign bus.m_o        = r_m;
    assign bus.rem_nz     = r_rem_nz;
    assign bus.c_o        = r_c;
    assign bus.d_o        = r_d;
    assign bus.err_div0   = r_err_div0;
    assign bus.err_ovf    = r_err_ovf;
    assign bus.err_parity = r_err_parity;
endmodule
`default_nettype wire

// File: tb/tb_mac_result_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_result_decoder
// Brief    : Directed + random scoreboard bench for mac_result_decoder.
// Revision : 1.0
// ============================================================================
module tb_mac_result_decoder;
    logic clk;
    logic rst;

    mac_result_decoder_if bus ();

    mac_result_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] m;
        logic        rem_nz;
        logic [15:0] c;
        logic [15:0] d;
        logic        e_div0;
        logic        e_ovf;
        logic        e_par;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference computed with native division, independent of the serial algorithm.
    function automatic exp_t model(input logic [30:0] a, input logic [45:0] prod,
                                   input logic [16:0] p, input logic [16:0] q);
        exp_t            e;
        logic [16:0]     s;
        logic [16:0]     df;
        longint unsigned quo;
        longint unsigned rm;
        e  = '0;
        s  = p + q;
        df = p - q;
        e.c     = s[16:1];
        e.d     = df[16:1];
        e.e_par = p[0] ^ q[0];
        if (a == 31'd0) begin
            e.e_div0 = 1'b1;
            e.lat    = 8'd1;
        end else begin
            quo = longint'(prod) / longint'(a);
            rm  = longint'(prod) % longint'(a);
            if (quo >= 64'd4096) begin
                e.e_ovf = 1'b1;
                e.lat   = 8'd1;
            end else begin
                e.m      = 12'(quo);
                e.rem_nz = (rm != 0);
                e.lat    = 8'd13;
            end
        end
        return e;
    endfunction

    task automatic run_txn(input string tag, input logic [30:0] a, input logic [45:0] prod,
                           input logic [16:0] p, input logic [16:0] q, input int hold);
        exp_t e;
        int   k;
        int   lat;
        bus.a_i      = a;
        bus.prod_i   = prod;
        bus.p_i      = p;
        bus.q_i      = q;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, ".in_ready_wait"}, 64'(bus.in_ready), 64'd1);
        sb.push_back(model(a, prod, p, q));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, ".busy"}, 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        check({tag, ".latency"}, 64'(lat), 64'(e.lat));
        check({tag, ".m_o"}, 64'(bus.m_o), 64'(e.m));
        check({tag, ".rem_nz"}, 64'(bus.rem_nz), 64'(e.rem_nz));
        check({tag, ".c_o"}, 64'(bus.c_o), 64'(e.c));
        check({tag, ".d_o"}, 64'(bus.d_o), 64'(e.d));
        check({tag, ".err_div0"}, 64'(bus.err_div0), 64'(e.e_div0));
        check({tag, ".err_ovf"}, 64'(bus.err_ovf), 64'(e.e_ovf));
        check({tag, ".err_parity"}, 64'(bus.err_parity), 64'(e.e_par));
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
                check({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
                check({tag, ".hold_m_o"}, 64'(bus.m_o), 64'(e.m));
                check({tag, ".hold_c_o"}, 64'(bus.c_o), 64'(e.c));
            end
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".post_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, ".post_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".post_m_o"}, 64'(bus.m_o), 64'(e.m));
    endtask

    initial begin
        logic [30:0]     ra;
        logic [11:0]     rmul;
        longint unsigned rr;
        int              k;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_i       = '0;
        bus.prod_i    = '0;
        bus.p_i       = '0;
        bus.q_i       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready_in_rst", 64'(bus.in_ready), 64'd0);
        check("reset.out_valid", 64'(bus.out_valid), 64'd0);
        check("reset.m_o", 64'(bus.m_o), 64'd0);
        check("reset.c_o", 64'(bus.c_o), 64'd0);
        check("reset.errs", 64'({bus.err_div0, bus.err_ovf, bus.err_parity, bus.rem_nz}), 64'd0);
        rst = 1'b0;
        #1;
        check("reset.in_ready_after", 64'(bus.in_ready), 64'd1);

        run_txn("exact", 31'd3, 46'd8244, 17'd1300, 17'd700, 0);
        run_txn("wrap", 31'd7, 46'd100, 17'd14, 17'd131068, 0);
        run_txn("div0", 31'd0, 46'd55, 17'd10, 17'd4, 0);
        run_txn("ovf", 31'd1, 46'd4096, 17'd2, 17'd2, 0);
        run_txn("max_q", 31'd1, 46'd4095, 17'd2, 17'd2, 0);
        run_txn("parity", 31'd2, 46'd10, 17'd3, 17'd0, 0);
        run_txn("backpressure", 31'd3, 46'd8244, 17'd1300, 17'd700, 5);

        // Abort mid-division with reset, then confirm a clean restart.
        bus.a_i      = 31'd7;
        bus.prod_i   = 46'd100;
        bus.p_i      = 17'd14;
        bus.q_i      = 17'd131068;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back(model(31'd7, 46'd100, 17'd14, 17'd131068));
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_front());
        #1;
        check("midrst.in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst.out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst.m_o", 64'(bus.m_o), 64'd0);
        check("midrst.c_o", 64'(bus.c_o), 64'd0);
        check("midrst.d_o", 64'(bus.d_o), 64'd0);
        check("midrst.errs", 64'({bus.err_div0, bus.err_ovf, bus.err_parity, bus.rem_nz}), 64'd0);
        k = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.out_valid) k++;
        end
        check("midrst.stays_idle", 64'(k), 64'd0);
        run_txn("after_rst", 31'd3, 46'd8244, 17'd1300, 17'd700, 0);

        for (int i = 0; i < 4; i++) begin
            ra = 31'($urandom);
            if (ra == 31'd0) ra = 31'd1;
            rmul = 12'($urandom);
            rr   = longint'($urandom) % longint'(ra);
            run_txn($sformatf("rand%0d", i), ra, 46'(longint'(ra) * longint'(rmul) + rr),
                    17'($urandom), 17'($urandom), (i == 1) ? 2 : 0);
        end

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
